// File: rtl/axi_lite_reg_top.sv
// AXI4-Lite slave exposing CTRL (R/W, 2 bits), STATUS (RO) and ERR (RO) word registers.
// CTRL drives the core's start/irq levels; STATUS/ERR are sampled at read acceptance.
module axi_lite_reg_top #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  start,
    output logic                  irq,
    input  logic [1:0]            status,
    input  logic [1:0]            err_code
);
    localparam int unsigned DATA_W = 32;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(4'h0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(4'h4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ERR    = ADDR_WIDTH'(4'h8);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [0:0]        w_state_q, w_state_d;
    logic [0:0]        r_state_q, r_state_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              aw_rdy_q, aw_rdy_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              ar_rdy_q, ar_rdy_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              wr_en;
    logic              rd_en;
    logic              wr_mapped_c;
    logic [DATA_W-1:0] rd_data_c;
    logic [1:0]        rd_resp_c;
    logic              unused_c;

    assign wr_en = awvalid & aw_rdy_q & wvalid & aw_rdy_q;
    assign rd_en = arvalid & ar_rdy_q;

    // Only the low CTRL byte lane carries stored bits.
    assign unused_c = ^{wdata[DATA_W-1:2], wstrb[3:1]};

    assign wr_mapped_c = (awaddr == ADDR_CTRL) || (awaddr == ADDR_STATUS) || (awaddr == ADDR_ERR);

    // Read decode; reads CTRL before any same-cycle write lands.
    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_OKAY;
        if (araddr == ADDR_CTRL) begin
            rd_data_c = DATA_W'(ctrl_q);
        end else if (araddr == ADDR_STATUS) begin
            rd_data_c = DATA_W'(status);
        end else if (araddr == ADDR_ERR) begin
            rd_data_c = DATA_W'(err_code);
        end else begin
            rd_resp_c = RESP_DECERR;
        end
    end

    // Write channel next-state.
    always_comb begin
        w_state_d = w_state_q;
        ctrl_d    = ctrl_q;
        aw_rdy_d  = aw_rdy_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (w_state_q == W_IDLE) begin
            if (wr_en) begin
                w_state_d = W_RESP;
                aw_rdy_d  = 1'b0;
                bvalid_d  = 1'b1;
                bresp_d   = wr_mapped_c ? RESP_OKAY : RESP_DECERR;
                if ((awaddr == ADDR_CTRL) && wstrb[0]) begin
                    ctrl_d = wdata[1:0];
                end
            end
        end else begin
            if (bvalid_q && bready) begin
                w_state_d = W_IDLE;
                aw_rdy_d  = 1'b1;
                bvalid_d  = 1'b0;
                bresp_d   = RESP_OKAY;
            end
        end
    end

    // Read channel next-state.
    always_comb begin
        r_state_d = r_state_q;
        ar_rdy_d  = ar_rdy_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        if (r_state_q == R_IDLE) begin
            if (rd_en) begin
                r_state_d = R_DATA;
                ar_rdy_d  = 1'b0;
                rvalid_d  = 1'b1;
                rresp_d   = rd_resp_c;
                rdata_d   = rd_data_c;
            end
        end else begin
            if (rvalid_q && rready) begin
                r_state_d = R_IDLE;
                ar_rdy_d  = 1'b1;
                rvalid_d  = 1'b0;
                rresp_d   = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            ctrl_q    <= '0;
            aw_rdy_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            ar_rdy_q  <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            ctrl_q    <= ctrl_d;
            aw_rdy_q  <= aw_rdy_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            ar_rdy_q  <= ar_rdy_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign awready = aw_rdy_q;
    assign wready  = aw_rdy_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = ar_rdy_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;
    assign start   = ctrl_q[0];
    assign irq     = ctrl_q[1];
endmodule

// File: tb/tb_axi_lite_reg_top.sv
// Scoreboard bench for axi_lite_reg_top: responses are predicted from a register model
// when a transaction is driven and compared when the DUT presents its response.
module tb_axi_lite_reg_top;
    logic        clk;
    logic        rst_n;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        start;
    logic        irq;
    logic [1:0]  status;
    logic [1:0]  err_code;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    rd_exp_t     rq[$];
    logic [1:0]  bq[$];
    logic [1:0]  ctrl_m;
    int          checks;
    int          failures;

    axi_lite_reg_top #(.ADDR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .start(start), .irq(irq), .status(status), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic rd_exp_t model_read(input logic [3:0] a);
        rd_exp_t e;
        e.resp = 2'b00;
        case (a)
            4'h0:    e.data = {30'b0, ctrl_m};
            4'h4:    e.data = {30'b0, status};
            4'h8:    e.data = {30'b0, err_code};
            default: begin e.data = 32'h0; e.resp = 2'b11; end
        endcase
        return e;
    endfunction

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        logic [1:0] eb;
        n = 0;
        @(negedge clk);
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!(awready && wready)) begin
            failures++;
            $display("FAIL wr_ready_timeout addr=%0h got=%b%b want=11", a, awready, wready);
        end
        bq.push_back((a == 4'h0 || a == 4'h4 || a == 4'h8) ? 2'b00 : 2'b11);
        if (a == 4'h0 && s[0]) ctrl_m = d[1:0];
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (!bvalid) begin
            failures++;
            $display("FAIL bvalid_timeout addr=%0h got=0 want=1", a);
            void'(bq.pop_front());
        end else begin
            eb = bq.pop_front();
            checks++;
            if (bresp !== eb) begin
                failures++;
                $display("FAIL bresp addr=%0h got=%b want=%b", a, bresp, eb);
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({bvalid, bresp} !== 3'b000) begin
            failures++;
            $display("FAIL b_idle addr=%0h got=%b want=000", a, {bvalid, bresp});
        end
    endtask

    task automatic do_read(input logic [3:0] a);
        int n;
        rd_exp_t e;
        n = 0;
        @(negedge clk);
        while (!arready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!arready) begin
            failures++;
            $display("FAIL arready_timeout addr=%0h got=0 want=1", a);
        end
        rq.push_back(model_read(a));
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
        e = rq.pop_front();
        checks++;
        if (!rvalid) begin
            failures++;
            $display("FAIL rvalid_timeout addr=%0h got=0 want=1", a);
        end else begin
            checks++;
            if (rdata !== e.data || rresp !== e.resp) begin
                failures++;
                $display("FAIL rd addr=%0h got=%h/%b want=%h/%b", a, rdata, rresp, e.data, e.resp);
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({rvalid, rresp} !== 3'b000 || rdata !== e.data) begin
            failures++;
            $display("FAIL r_idle addr=%0h got=%b/%h want=000/%h", a, {rvalid, rresp}, rdata, e.data);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, start, irq} !== 11'b111_00_0000_00) begin
            failures++;
            $display("FAIL reset_ctl got=%b want=11100000000",
                     {awready, wready, arready, bvalid, rvalid, bresp, rresp, start, irq});
        end
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h want=0", rdata);
        end
        do_read(4'h0);
        do_read(4'h4);
        do_read(4'h8);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b want=0", irq);
        end
    endtask

    task automatic test_ctrl_writes();
        logic [31:0] vals [6];
        logic [1:0]  outs [6];
        vals = '{32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0};
        outs = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 6; i++) begin
            do_write(4'h0, vals[i], 4'hF);
            checks++;
            if ({irq, start} !== outs[i]) begin
                failures++;
                $display("FAIL ctrl_out val=%h got=%b want=%b", vals[i], {irq, start}, outs[i]);
            end
            do_read(4'h0);
        end
    endtask

    task automatic test_addr_sweep();
        for (int a = 0; a < 16; a++) begin
            do_write(4'(a), 32'hFFFFFFFF, 4'hF);
            do_read(4'(a));
        end
    endtask

    task automatic test_lone_valid();
        do_write(4'h0, 32'h0, 4'hF);
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            awaddr = 4'h0; wdata = 32'hFFFFFFFF; wstrb = 4'hF; bready = 1'b1;
            wvalid = (p == 0); awvalid = (p == 1);
            for (int c = 0; c < 2; c++) begin
                @(posedge clk); #1;
                checks++;
                if ({dut.wr_en, bvalid, bresp} !== 4'b0000) begin
                    failures++;
                    $display("FAIL lone_valid phase=%0d got=%b want=0000", p, {dut.wr_en, bvalid, bresp});
                end
            end
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if ({irq, start} !== 2'b00) begin
            failures++;
            $display("FAIL lone_ctrl got=%b want=00", {irq, start});
        end
        do_read(4'h0);
    endtask

    task automatic test_no_read();
        @(negedge clk);
        araddr = 4'h0; arvalid = 1'b0; rready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({dut.rd_en, rvalid, rresp} !== 4'b0000) begin
                failures++;
                $display("FAIL no_read got=%b want=0000", {dut.rd_en, rvalid, rresp});
            end
        end
    endtask

    task automatic test_odd_value();
        do_write(4'h0, 32'h98761245, 4'hF);
        checks++;
        if ({irq, start} !== 2'b01) begin
            failures++;
            $display("FAIL odd_ctrl got=%b want=01", {irq, start});
        end
        do_read(4'h0);
        do_write(4'h0, 32'h00000002, 4'b1110);
        checks++;
        if ({irq, start} !== 2'b01) begin
            failures++;
            $display("FAIL strb_masked got=%b want=01", {irq, start});
        end
        do_read(4'h0);
    endtask

    task automatic test_simultaneous();
        rd_exp_t e;
        logic [1:0] eb;
        @(negedge clk);
        rq.push_back(model_read(4'h0));
        bq.push_back(2'b00);
        ctrl_m = 2'b10;
        awaddr = 4'h0; wdata = 32'h2; wstrb = 4'hF; araddr = 4'h0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        e = rq.pop_front();
        eb = bq.pop_front();
        checks++;
        if ({bvalid, bresp, rvalid, rresp, rdata} !== {1'b1, eb, 1'b1, e.resp, e.data}) begin
            failures++;
            $display("FAIL simul got=%b%b/%b%b/%h want=1%b/1%b/%h",
                     bvalid, bresp, rvalid, rresp, rdata, eb, e.resp, e.data);
        end
        @(posedge clk); #1;
        checks++;
        if ({irq, start} !== 2'b10) begin
            failures++;
            $display("FAIL simul_ctrl got=%b want=10", {irq, start});
        end
        do_read(4'h0);
    endtask

    task automatic test_bready_stall();
        @(negedge clk);
        bq.push_back(2'b11);
        awaddr = 4'h3; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({bvalid, awready, wready, bresp} !== {3'b100, bq[0]}) begin
                failures++;
                $display("FAIL stall cyc=%0d got=%b want=100%b", c, {bvalid, awready, wready, bresp}, bq[0]);
            end
            @(posedge clk); #1;
        end
        void'(bq.pop_front());
        bready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bvalid, awready, bresp} !== 4'b0100) begin
            failures++;
            $display("FAIL stall_release got=%b want=0100", {bvalid, awready, bresp});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ctrl_m = 2'b11;
        awaddr = 4'h0; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if ({bvalid, irq, start} !== 3'b111) begin
            failures++;
            $display("FAIL pre_reset got=%b want=111", {bvalid, irq, start});
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        ctrl_m = 2'b00;
        checks++;
        if ({bvalid, awready, wready, arready, irq, start, bresp} !== 8'b0111_0000) begin
            failures++;
            $display("FAIL mid_reset got=%b want=01110000", {bvalid, awready, wready, arready, irq, start, bresp});
        end
        @(negedge clk);
        rst_n = 1'b1;
        bready = 1'b1;
        do_read(4'h0);
    endtask

    initial begin
        checks = 0; failures = 0; ctrl_m = 2'b00;
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        status = 2'd3; err_code = 2'd2;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_reset();
        test_ctrl_writes();
        test_addr_sweep();
        test_lone_valid();
        test_no_read();
        test_odd_value();
        test_simultaneous();
        test_bready_stall();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_lite_reg_top.md
# axi_lite_reg_top

Control/status register block behind a 32-bit AXI4-Lite slave port. It decodes three word registers: a writable 2-bit CTRL, a read-only STATUS and a read-only ERR code. It drives `start` and `irq` from CTRL into the processing core. It sits between the system interconnect and the histogram engine.

## Interface
- ADDR_WIDTH, 4: byte-address width of AW/AR channels.
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- awaddr  in  ADDR_WIDTH  write byte address.
- awvalid / awready  in / out  1  write-address handshake.
- wdata  in  32  write data.
- wstrb  in  4  byte strobes.
- wvalid / wready  in / out  1  write-data handshake.
- bresp  out  2  write response.
- bvalid / bready  out / in  1  write-response handshake.
- araddr  in  ADDR_WIDTH  read byte address.
- arvalid / arready  in / out  1  read-address handshake.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rvalid / rready  out / in  1  read-data handshake.
- start  out  1  CTRL[0], level.
- irq  out  1  CTRL[1], level.
- status  in  2  core status, sampled on read.
- err_code  in  2  core error code, sampled on read.

## Operation
- Register map (full ADDR_WIDTH decode, byte addresses):
  - 0x0 CTRL: R/W; bits [1:0] stored; bits [31:2] read 0.
  - 0x4 STATUS: RO; reads {30'b0, status}.
  - 0x8 ERR: RO; reads {30'b0, err_code}.
  - Any other address, including unaligned 1,2,3,5,…,15: unmapped.
- Write to CTRL updates bits [1:0] from wdata[1:0] only if wstrb[0]=1; other strobe bits are ignored.
- Write to STATUS/ERR: data discarded, BRESP=2'b00 (OKAY).
- Write to unmapped: no state change, BRESP=2'b11 (DECERR).
- Read mapped: RRESP=2'b00. Read unmapped: RDATA=0, RRESP=2'b11.
- Internal strobes:
  - wr_en = awvalid & awready & wvalid & wready.
  - rd_en = arvalid & arready.
  - Both are one-cycle pulses; register update and read capture occur only on these.
- Write accepted only when awvalid and wvalid are high in the same cycle. A lone awvalid or lone wvalid is not latched: no wr_en, no bvalid, no state change.
- Read and write channels are independent and may complete in the same cycle. A simultaneous read of CTRL returns the pre-write value.
- Reset values:
  - CTRL=0, start=0, irq=0.
  - awready=wready=arready=1 (idle).
  - bvalid=rvalid=0, bresp=rresp=2'b00, rdata=0.

## Timing
- Write FSM, W_IDLE -> W_RESP:
  - In W_IDLE, awready=wready=1.
  - On the edge where awvalid&wvalid: CTRL is written, bvalid=1 and bresp is registered, readies drop, state -> W_RESP.
  - In W_RESP, bvalid holds until bvalid&bready. On that edge bvalid=0, bresp returns to 00, state -> W_IDLE.
- Read FSM, R_IDLE -> R_DATA:
  - In R_IDLE, arready=1.
  - On the edge where arvalid: rdata/rresp are registered from decode, rvalid=1, state -> R_DATA.
  - In R_DATA, hold until rvalid&rready. Then rvalid=0, rresp=00, rdata holds its last value, state -> R_IDLE.
- Latency: response valid on the handshake edge itself (visible 1 cycle after inputs presented). start/irq change on the write-handshake edge.
- bresp/rresp are 2'b00 whenever their valid is low.
- Reset asserted mid-transaction aborts immediately to the reset values; a pending response is dropped.

## Test plan
- After reset, read 0x0/0x4/0x8 with status=3, err_code=2 -> 0x0, 0x3, 0x2, RRESP 00; irq=0.
- CTRL writes, each followed by a read of 0x0:
  - 0xFFFFFFFF -> 0x3, irq=1.
  - 0xAAAAAAAA -> 0x2, irq=1.
  - 0x55555555 -> 0x1, irq=0, start=1.
  - 0xA5A5A5A5 -> 0x1.
  - 0x5A5A5A5A -> 0x2.
  - 0x0 -> 0x0.
- Write 0xFFFFFFFF to each address 0..15:
  - 0/4/8 -> BRESP 00, readback 3/3/2.
  - Others -> BRESP 11, read RDATA 0 with RRESP 11.
- Hold wvalid=1, awvalid=0 (then the reverse, then both 0) for 2 cycles -> wr_en=0, bvalid=0, bresp=00; CTRL stays 0.
- arvalid=0 with rready=1 for 2 cycles -> rd_en=0, rvalid=0, rresp=00.
- Write CTRL=0x98761245, then read -> 0x1, irq=0.
- Write CTRL=3, pulse rst_n low for 1 cycle -> CTRL reads 0.
